seq_pattern_tx: RTL

Serial bit-pattern transmitter. It drives a programmable PAT_W-bit pattern MSB-first onto a single-bit line, repeated a requested number of times, with optional idle gaps between repetitions. It is the stimulus/transmit side for the serial sequence detectors (e.g. the 1101 Moore detector). Its x_out connects directly to a detector's x input on the same clk.

---
 rtl/seq_pkg.sv | 14 +
 rtl/seq_pattern_tx_if.sv | 28 ++
 rtl/seq_down_cnt.sv | 30 +++
 rtl/seq_pattern_tx.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and defaults for the serial pattern transmitter family.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam logic [3:0] SEQ_1101     = 4'b1101;
  localparam logic       SEQ_IDLE_BIT = 1'b0;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Command/status bundle between a pattern-transmit controller (master) and seq_pattern_tx (slave).
interface seq_pattern_tx_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
);
  localparam int IW = $clog2(PAT_W);

  logic             start;
  logic             pattern_ld;
  logic [PAT_W-1:0] pattern_in;
  logic [CNT_W-1:0] repeat_n;
  logic             hold;
  logic             x_out;
  logic             x_valid;
  logic             busy;
  logic             done;
  logic [IW-1:0]    bit_idx;

  modport master (
    output start, pattern_ld, pattern_in, repeat_n, hold,
    input  x_out, x_valid, busy, done, bit_idx
  );

  modport slave (
    input  start, pattern_ld, pattern_in, repeat_n, hold,
    output x_out, x_valid, busy, done, bit_idx
  );
endinterface

// File: rtl/seq_down_cnt.sv
// Loadable down-counter with enable and zero flag; load wins over enable, saturates at zero.
// One-cycle update; no backpressure beyond the caller gating i_en/i_ld.
module seq_down_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_ld,
  input  logic [W-1:0] i_ld_val,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_ld) begin
      r_cnt <= i_ld_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends pat_reg MSB-first repeat_n times, optional idle gaps; first bit one cycle after start.
// hold freezes every register and output; start/pattern_ld are honoured only in IDLE.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int               PAT_W    = 4,
  parameter logic [PAT_W-1:0] PATTERN  = PAT_W'(SEQ_1101),
  parameter int               CNT_W    = 4,
  parameter int               GAP_BITS = 0,
  parameter logic             IDLE_BIT = SEQ_IDLE_BIT
) (
  input  logic           clk,
  input  logic           rst,
  seq_pattern_tx_if.slave bus
);

  localparam int             IW      = $clog2(PAT_W);
  localparam int             GW      = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
  localparam logic [IW-1:0]  MSB_IDX = IW'(PAT_W - 1);
  localparam logic [GW-1:0]  GAP_LD  = GW'(GAP_BITS);
  localparam bit             HAS_GAP = (GAP_BITS > 0);

  seq_state_t       r_state;
  logic             r_x_out;
  logic             r_x_valid;
  logic             r_busy;
  logic             r_done;
  logic [PAT_W-1:0] r_pat;

  logic [IW-1:0]    w_bit_cnt;
  logic [IW-1:0]    w_bit_dn;
  logic             w_bit_zero;
  logic [CNT_W-1:0] w_rep_cnt;
  logic             w_rep_zero;
  logic [GW-1:0]    w_gap_cnt;
  logic             w_gap_zero;
  logic [PAT_W-1:0] w_pat_src;

  logic w_run, w_idle_start, w_launch, w_end_pat, w_rep_last, w_rep_more;
  logic w_gap_last, w_gap_exit;

  assign w_run        = !bus.hold;
  assign w_idle_start = w_run && (r_state == IDLE) && bus.start;
  assign w_launch     = w_idle_start && (bus.repeat_n != '0);
  assign w_end_pat    = w_run && (r_state == SHIFT) && w_bit_zero;
  // Zero is treated like one so a counter can never be walked past its floor.
  assign w_rep_last   = w_rep_zero || (w_rep_cnt == CNT_W'(1));
  assign w_rep_more   = w_end_pat && !w_rep_last;
  assign w_gap_last   = w_gap_zero || (w_gap_cnt == GW'(1));
  assign w_gap_exit   = w_run && (r_state == GAP) && w_gap_last;
  assign w_bit_dn     = w_bit_cnt - IW'(1);
  assign w_pat_src    = bus.pattern_ld ? bus.pattern_in : r_pat;

  seq_down_cnt #(.W(IW)) u_bit_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_ld     (w_launch || (w_rep_more && !HAS_GAP) || w_gap_exit),
    .i_ld_val (MSB_IDX),
    .i_en     (w_run && (r_state == SHIFT) && !w_bit_zero),
    .o_cnt    (w_bit_cnt),
    .o_zero   (w_bit_zero)
  );

  seq_down_cnt #(.W(CNT_W)) u_rep_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_ld     (w_idle_start),
    .i_ld_val (bus.repeat_n),
    .i_en     (w_rep_more),
    .o_cnt    (w_rep_cnt),
    .o_zero   (w_rep_zero)
  );

  seq_down_cnt #(.W(GW)) u_gap_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_ld     (w_rep_more && HAS_GAP),
    .i_ld_val (GAP_LD),
    .i_en     (w_run && (r_state == GAP)),
    .o_cnt    (w_gap_cnt),
    .o_zero   (w_gap_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_x_out   <= IDLE_BIT;
      r_x_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pat     <= PATTERN;
    end else if (w_run) begin
      case (r_state)
        IDLE: begin
          if (bus.pattern_ld) r_pat <= bus.pattern_in;
          if (bus.start) begin
            r_busy <= 1'b1;
            if (bus.repeat_n == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state   <= SHIFT;
              r_x_out   <= w_pat_src[PAT_W-1];
              r_x_valid <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (!w_bit_zero) begin
            r_x_out <= r_pat[w_bit_dn];
          end else if (w_rep_last) begin
            r_state   <= DONE;
            r_done    <= 1'b1;
            r_x_out   <= IDLE_BIT;
            r_x_valid <= 1'b0;
          end else if (HAS_GAP) begin
            r_state   <= GAP;
            r_x_out   <= IDLE_BIT;
            r_x_valid <= 1'b0;
          end else begin
            r_x_out <= r_pat[PAT_W-1];
          end
        end
        GAP: begin
          if (w_gap_last) begin
            r_state   <= SHIFT;
            r_x_out   <= r_pat[PAT_W-1];
            r_x_valid <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.x_out   = r_x_out;
  assign bus.x_valid = r_x_valid;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.bit_idx = w_bit_cnt;

endmodule
